remote_update_wdc_fifo: RTL and testbench
=========================================

# remote_update_wdc_fifo

Synchronous, parametrised width-down-converting FIFO for the remote-update datapath. The host side writes wide words and the flash-programming side drains narrow words. Lane order, depth and ratio are configurable, almost-full and almost-empty thresholds are programmable at run time, and the block has a synchronous flush plus sticky overflow and underflow error flags. It replaces the fixed 32→8, 512-deep vendor FIFO in the remote-update write path.

## Interface
- `RD_WIDTH`, 8: read word width in bits.
- `RATIO`, 4: write/read width ratio; power of two, 1..16. `WR_WIDTH = RD_WIDTH*RATIO`.
- `WR_DEPTH_LOG2`, 9: log2 of storage depth in wide words.
- `MSB_FIRST`, 1: 1 = most-significant lane is read first; 0 = least-significant lane first.
- Derived: `RL2 = log2(RATIO)`; `LVL_W = WR_DEPTH_LOG2 + RL2 + 1`.
- `clk` in 1: clock. Reset is `rst`, asynchronous, active-high; clock is `clk`.
- `rst` in 1: async reset, active-high.
- `flush` in 1: synchronous clear of contents and error flags.
- `wr_en` in 1: write request.
- `wr_data` in `WR_WIDTH`: write word.
- `wr_full` out 1: no free wide slot.
- `almost_full` out 1: `rd_water_level >= af_thresh`.
- `af_thresh` in `LVL_W`: almost-full threshold, in read words.
- `rd_en` in 1: read request.
- `rd_data` out `RD_WIDTH`: read word.
- `rd_valid` out 1: `rd_data` carries a newly read word this cycle.
- `rd_empty` out 1: `rd_water_level == 0`.
- `almost_empty` out 1: `rd_water_level <= ae_thresh`.
- `ae_thresh` in `LVL_W`: almost-empty threshold, in read words.
- `rd_water_level` out `LVL_W`: stored read words.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- **Storage:** simple dual-port RAM, 2^`WR_DEPTH_LOG2` × `WR_WIDTH`.
- **Write pointer:** `wp`, `WR_DEPTH_LOG2+1` bits, counts wide words.
- **Read pointer:** `rp`, `LVL_W` bits, counts narrow words.
  - RAM read address is `rp[LVL_W-2:RL2]`.
  - Lane index is `rp[RL2-1:0]`, or the bitwise inverse of that when `MSB_FIRST=1`.
- **Level:** `rd_water_level = (wp << RL2) - rp`, computed modulo 2^`LVL_W`.
- **Full:** `wr_full = (wp - rp[LVL_W-1:RL2]) == 2^WR_DEPTH_LOG2`. A partially drained wide word still occupies its slot.
- **Write accepted:** when `wr_en & ~wr_full & ~flush`. The RAM is written at `wp` and `wp` increments.
- **Write refused:** `wr_en & wr_full` drops the data and sets `overflow`.
- **Read accepted:** when `rd_en & ~rd_empty & ~flush`. The lane is fetched and `rp` increments.
- **Read refused:** `rd_en & rd_empty` is ignored and sets `underflow`.
- **Simultaneous write and read:** both are evaluated against pre-edge flags.
  - Write while full is refused even if a read is accepted in the same cycle.
  - Read while empty is refused even if a write is accepted in the same cycle.
- **Pointer wrap:** wrap is natural binary; the extra MSB distinguishes full from empty.
- **Flush:** has priority over `wr_en`/`rd_en` in the same cycle.
  - `wp`, `rp`, `overflow`, `underflow` and `rd_valid` clear on the next edge.
  - `rd_data` holds its value.
- **Thresholds:** sampled continuously; changing a threshold affects the flag combinationally from registered pointers.
- **Reset values:**

| Output | Reset value |
|---|---|
| `wr_full` | 0 |
| `rd_empty` | 1 |
| `almost_empty` | 1 |
| `almost_full` | `af_thresh == 0` |
| `rd_water_level` | 0 |
| `rd_data` | 0 |
| `rd_valid` | 0 |
| `overflow` | 0 |
| `underflow` | 0 |

## Timing
- **Flags and level:** combinational from registered pointers, so they update in the cycle after the accepting edge.
- **Read latency:** `rd_data` and `rd_valid` are valid 1 cycle after the edge that accepts `rd_en`.
  - `rd_valid` is high for exactly 1 cycle per accepted read.
  - `rd_data` holds its value when no read is accepted.
- **Write-to-read latency:** a write accepted at edge N makes `rd_empty` fall after edge N; a read is then accepted at edge N+1 at the earliest.
- **Throughput:** one read per cycle sustained; one wide write per cycle as long as the FIFO is not full.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous); RAM contents are don't-care.

## Configuration
- **`RUPD_WDC_FIFO_OUTREG_EN`:** when defined, adds an output register after the lane mux.
  - Read latency becomes 2 cycles.
  - `rd_valid` is delayed to match.
  - Flags and level are unchanged.
  - Flush clears the pipeline `rd_valid` stage.
- **When undefined:** read latency is 1 cycle, as specified in Timing.

## Structure
- **Package `rupd_fifo_pkg`:**
  - `clog2` function.
  - `MSB_FIRST` encoding constants.
  - Level-width helper `lvl_w(depth_log2, ratio)`.
- **Sub-module `rupd_sdp_ram`:** parametrised width and depth, registered read, no reset on the array.
- **Top level:** pointers, flags, lane mux and error logic stay in the top module.

## Test plan
All scenarios use `RD_WIDTH=8`, `RATIO=4`, `WR_DEPTH_LOG2=2` unless stated.

1. **Lane order and latency:** write `0x44332211`, then read 4 times.
   - With `MSB_FIRST=1`: `rd_data` = 44, 33, 22, 11.
   - With `MSB_FIRST=0`: `rd_data` = 11, 22, 33, 44.
   - `rd_valid` is high 1 cycle after each `rd_en`.
2. **Full and overflow:** write 4 words → `wr_full=1`, level=16.
   - A 5th write is dropped and `overflow=1`.
   - Read 1 lane → `wr_full` stays 1 (level=15).
   - Read 3 more lanes → `wr_full=0`.
3. **Empty and underflow:** `rd_en` on an empty FIFO → `underflow=1`, `rd_valid=0`, `rp` unchanged.
   - Same-cycle `wr_en` and `rd_en` on an empty FIFO: the write is accepted and the read is refused.
4. **Thresholds:** set `af_thresh=12`, `ae_thresh=3`.
   - After 3 writes: level=12, `almost_full=1`.
   - After draining 9 lanes: level=3, `almost_empty=1`.
5. **Wrap:** run 40 wide writes interleaved with 160 reads, checking data continuity against a model with no gaps or duplicates.
6. **Flush and reset:** fill 3 words, set `overflow`, then pulse `flush` together with `wr_en`.
   - Next cycle: level=0, `rd_empty=1`, `overflow=0`, and the write is discarded.
   - Asserting `rst` mid-read clears `rd_valid` immediately.

Source files
------------

// File: rtl/rupd_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the remote-update WDC FIFO.
// Latency: none (package only).
// Backpressure: n/a.
package rupd_fifo_pkg;

    // Lane-order encodings for the MSB_FIRST parameter
    localparam int LANE_ORDER_LSB_FIRST = 0;
    localparam int LANE_ORDER_MSB_FIRST = 1;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a read-word count: depth bits + lane bits + one wrap bit
    function automatic int lvl_w(input int depth_log2, input int ratio);
        return depth_log2 + clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/rupd_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears 1 cycle after i_re; output holds while i_re is low.
// Backpressure: none; caller guarantees no same-slot read/write collision.
module rupd_sdp_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rdata;

    // Array write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; the output register resets so downstream sees zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/remote_update_wdc_fifo.sv
// Width-down-converting FIFO: wide host writes, narrow flash-side reads; macro RUPD_WDC_FIFO_OUTREG_EN adds an output register.
// Latency: rd_data/rd_valid 1 cycle after an accepted rd_en (2 with RUPD_WDC_FIFO_OUTREG_EN); flags update the cycle after the accepting edge.
// Backpressure: writes while wr_full are dropped (overflow), reads while rd_empty are ignored (underflow); both flags sticky until flush/rst.
module remote_update_wdc_fifo
    import rupd_fifo_pkg::*;
#(
    parameter  int RD_WIDTH      = 8,
    parameter  int RATIO         = 4,
    parameter  int WR_DEPTH_LOG2 = 9,
    parameter  int MSB_FIRST     = 1,
    localparam int WR_WIDTH      = RD_WIDTH * RATIO,
    localparam int RL2           = clog2(RATIO),
    localparam int LVL_W         = lvl_w(WR_DEPTH_LOG2, RATIO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [WR_WIDTH-1:0] wr_data,
    output logic                wr_full,
    output logic                almost_full,
    input  logic [LVL_W-1:0]    af_thresh,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                rd_empty,
    output logic                almost_empty,
    input  logic [LVL_W-1:0]    ae_thresh,
    output logic [LVL_W-1:0]    rd_water_level,
    output logic                overflow,
    output logic                underflow
);

    localparam int LANE_W = (RL2 > 0) ? RL2 : 1;
    localparam logic [WR_DEPTH_LOG2:0] FULL_SLOTS = (WR_DEPTH_LOG2 + 1)'(1) << WR_DEPTH_LOG2;

    logic [WR_DEPTH_LOG2:0] r_wp;
    logic [LVL_W-1:0]       r_rp;
    logic [LANE_W-1:0]      r_lane;
    logic                   r_vld;
    logic                   r_overflow;
    logic                   r_underflow;

    logic [LVL_W-1:0]       w_level;
    logic [WR_DEPTH_LOG2:0] w_slots_used;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [LANE_W-1:0]      w_lane_seq;
    logic [LANE_W-1:0]      w_lane;
    logic [WR_WIDTH-1:0]    w_ram_q;
    logic [RD_WIDTH-1:0]    w_lane_dat;

    // Level in read words; a partially drained wide word still holds its slot for the full check
    assign w_level      = (LVL_W'(r_wp) << RL2) - r_rp;
    assign w_slots_used = r_wp - r_rp[LVL_W-1:RL2];
    assign w_full       = (w_slots_used == FULL_SLOTS);
    assign w_empty      = (w_level == '0);

    // Both accepts use pre-edge flags, so a same-cycle read never frees room for a write and vice versa
    assign w_wr_acc = wr_en & ~w_full & ~flush;
    assign w_rd_acc = rd_en & ~w_empty & ~flush;

    // Lane select: low rp bits count lanes; MSB-first walks them downwards
    assign w_lane_seq = LANE_W'(r_rp & LVL_W'(RATIO - 1));
    assign w_lane     = (MSB_FIRST == LANE_ORDER_MSB_FIRST) ? (LANE_W'(RATIO - 1) - w_lane_seq) : w_lane_seq;

    rupd_sdp_ram #(
        .WIDTH      (WR_WIDTH),
        .DEPTH_LOG2 (WR_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wp[WR_DEPTH_LOG2-1:0]),
        .i_wdata (wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rp[LVL_W-2:RL2]),
        .o_rdata (w_ram_q)
    );

    // Pointer update; flush wins over both requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_acc) r_wp <= r_wp + 1'b1;
            if (w_rd_acc) r_rp <= r_rp + 1'b1;
        end
    end

    // Lane latched alongside the RAM read so the mux tracks the word being presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
            r_vld  <= 1'b0;
        end else begin
            if (w_rd_acc) r_lane <= w_lane;
            r_vld <= w_rd_acc;
        end
    end

    // Sticky error flags, cleared only by flush or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & w_full)  r_overflow  <= 1'b1;
            if (rd_en & w_empty) r_underflow <= 1'b1;
        end
    end

    // Lane mux from the registered RAM word
    always_comb begin
        w_lane_dat = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_lane_dat = w_ram_q[i*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

`ifdef RUPD_WDC_FIFO_OUTREG_EN
    logic                r_vld_out;
    logic [RD_WIDTH-1:0] r_rd_data;

    // Output stage: one extra cycle of latency, flush kills anything in flight, data holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_out <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_vld_out <= r_vld & ~flush;
            if (r_vld & ~flush) r_rd_data <= w_lane_dat;
        end
    end

    assign rd_valid = r_vld_out;
    assign rd_data  = r_rd_data;
`else
    assign rd_valid = r_vld;
    assign rd_data  = w_lane_dat;
`endif

    assign wr_full        = w_full;
    assign rd_empty       = w_empty;
    assign rd_water_level = w_level;
    assign almost_full    = (w_level >= af_thresh);
    assign almost_empty   = (w_level <= ae_thresh);
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_remote_update_wdc_fifo.sv
// Bench for remote_update_wdc_fifo: two instances (MSB-first and LSB-first lane order) on shared stimulus.
// Latency: expected read results are scheduled by negedge index; the monitor checks them as they fall due.
// Backpressure: a queue-of-lanes model predicts accept/refuse, flags and sticky errors.
module tb_remote_update_wdc_fifo;

    localparam int RDW   = 8;
    localparam int RAT   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int LVW   = 5;
`ifdef RUPD_WDC_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [31:0]    wr_data = '0;
    logic [LVW-1:0] af_thresh = '0;
    logic [LVW-1:0] ae_thresh = '0;

    logic           m_full, m_af, m_vld, m_empty, m_ae, m_ovf, m_unf;
    logic [RDW-1:0] m_data;
    logic [LVW-1:0] m_lvl;
    logic           l_full, l_af, l_vld, l_empty, l_ae, l_ovf, l_unf;
    logic [RDW-1:0] l_data;
    logic [LVW-1:0] l_lvl;

    remote_update_wdc_fifo #(.RD_WIDTH(RDW), .RATIO(RAT), .WR_DEPTH_LOG2(DL2), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(m_full), .almost_full(m_af), .af_thresh(af_thresh), .rd_en(rd_en),
        .rd_data(m_data), .rd_valid(m_vld), .rd_empty(m_empty), .almost_empty(m_ae),
        .ae_thresh(ae_thresh), .rd_water_level(m_lvl), .overflow(m_ovf), .underflow(m_unf)
    );

    remote_update_wdc_fifo #(.RD_WIDTH(RDW), .RATIO(RAT), .WR_DEPTH_LOG2(DL2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(l_full), .almost_full(l_af), .af_thresh(af_thresh), .rd_en(rd_en),
        .rd_data(l_data), .rd_valid(l_vld), .rd_empty(l_empty), .almost_empty(l_ae),
        .ae_thresh(ae_thresh), .rd_water_level(l_lvl), .overflow(l_ovf), .underflow(l_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        tgt;
        logic [7:0] dm;
        logic [7:0] dl;
    } exp_t;

    exp_t       exq[$];
    logic [7:0] mq_m[$];
    logic [7:0] mq_l[$];
    bit         mod_ov = 1'b0;
    bit         mod_un = 1'b0;
    int         nc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic bit mod_full();
        return ((mq_m.size() + RAT - 1) / RAT) == DEPTH;
    endfunction

    function automatic bit mod_empty();
        return mq_m.size() == 0;
    endfunction

    task automatic chk_flags();
        int lvl;
        lvl = mq_m.size();
        chk("level",        32'(m_lvl),   32'(lvl));
        chk("level_lsb",    32'(l_lvl),   32'(lvl));
        chk("wr_full",      32'(m_full),  32'(mod_full()));
        chk("rd_empty",     32'(m_empty), 32'(mod_empty()));
        chk("almost_full",  32'(m_af),    32'(lvl >= int'(af_thresh)));
        chk("almost_empty", 32'(m_ae),    32'(lvl <= int'(ae_thresh)));
        chk("overflow",     32'(m_ovf),   32'(mod_ov));
        chk("underflow",    32'(m_unf),   32'(mod_un));
    endtask

    // Monitor: pops expected reads when due, flags missing or spurious rd_valid
    always @(negedge clk) begin
        nc++;
        if (!rst) begin
            if (exq.size() > 0 && exq[0].tgt < nc) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_missing: got rd_valid 0 expected 1 at negedge %0d", exq[0].tgt);
                void'(exq.pop_front());
            end
            if (exq.size() > 0 && exq[0].tgt == nc) begin
                chk("rd_valid_msb", 32'(m_vld),  32'd1);
                chk("rd_valid_lsb", 32'(l_vld),  32'd1);
                chk("rd_data_msb",  32'(m_data), 32'(exq[0].dm));
                chk("rd_data_lsb",  32'(l_data), 32'(exq[0].dl));
                void'(exq.pop_front());
            end else if (m_vld || l_vld) begin
                chk("rd_valid_spurious", {30'd0, m_vld, l_vld}, 32'd0);
            end
        end
    end

    // One clock of stimulus: predict from pre-edge model state, then check flags after the edge
    task automatic step(input bit we, input logic [31:0] wd, input bit re, input bit fl);
        bit   full;
        bit   empty;
        exp_t e;
        full  = mod_full();
        empty = mod_empty();
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        if (fl) begin
            mq_m.delete(); mq_l.delete(); exq.delete();
            mod_ov = 1'b0; mod_un = 1'b0;
        end else begin
            if (we && full)  mod_ov = 1'b1;
            if (re && empty) mod_un = 1'b1;
            if (re && !empty) begin
                e.tgt = nc + LAT;
                e.dm  = mq_m.pop_front();
                e.dl  = mq_l.pop_front();
                exq.push_back(e);
            end
            if (we && !full) begin
                for (int i = RAT - 1; i >= 0; i--) mq_m.push_back(wd[i*8 +: 8]);
                for (int i = 0; i < RAT; i++)      mq_l.push_back(wd[i*8 +: 8]);
            end
        end
        @(negedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        chk_flags();
    endtask

    initial begin
        int         nw;
        int         nr;
        int         iter;
        bit         we;
        bit         re;
        logic [7:0] hold;

        // Reset state, with af_thresh = 0 so almost_full reads 1
        repeat (2) @(negedge clk);
        #1;
        chk_flags();
        chk("rst_rd_data",  32'(m_data), 32'd0);
        chk("rst_rd_valid", 32'(m_vld),  32'd0);
        rst = 1'b0;
        af_thresh = 5'd16;
        ae_thresh = 5'd0;
        step(0, '0, 0, 0);

        // Lane order and latency
        step(1, 32'h44332211, 0, 0);
        repeat (4) step(0, '0, 1, 0);
        repeat (2) step(0, '0, 0, 0);

        // Full and overflow, then partial drain keeps the slot
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
        step(1, 32'hDEADBEEF, 0, 0);
        step(0, '0, 1, 0);
        repeat (3) step(0, '0, 1, 0);
        repeat (12) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Empty and underflow, then same-cycle write and read on empty
        step(0, '0, 1, 0);
        step(1, 32'hA5B6C7D8, 1, 0);
        repeat (4) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Thresholds
        step(0, '0, 0, 1);
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        repeat (3) step(1, $urandom, 0, 0);
        repeat (9) step(0, '0, 1, 0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Wrap: 40 accepted wide writes and 160 accepted reads, randomly interleaved
        af_thresh = 5'd16;
        ae_thresh = 5'd0;
        step(0, '0, 0, 1);
        nw = 0; nr = 0; iter = 0;
        while ((nw < 40 || nr < 160) && iter < 3000) begin
            we = (nw < 40) && ($urandom_range(0, 1) == 1);
            re = (nr < 160) && ($urandom_range(0, 3) != 0);
            if (we && !mod_full())  nw++;
            if (re && !mod_empty()) nr++;
            step(we, $urandom, re, 0);
            iter++;
        end
        chk("wrap_done", 32'((nw == 40) && (nr == 160)), 32'd1);
        repeat (3) step(0, '0, 0, 0);

        // Flush with a pending write; rd_data holds
        step(0, '0, 0, 1);
        repeat (3) step(1, $urandom, 0, 0);
        step(1, 32'h0badf00d, 0, 0);
        step(1, 32'h12345678, 0, 0);
        step(0, '0, 1, 0);
        repeat (LAT + 1) step(0, '0, 0, 0);
        hold = m_data;
        step(1, 32'hCAFEBABE, 0, 1);
        chk("flush_rd_data_hold", 32'(m_data), 32'(hold));
        step(0, '0, 0, 0);

        // Asynchronous reset mid-read
        step(1, 32'h87654321, 0, 0);
        step(0, '0, 1, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_rd_valid_msb", 32'(m_vld), 32'd0);
        chk("rst_async_rd_valid_lsb", 32'(l_vld), 32'd0);
        mq_m.delete(); mq_l.delete(); exq.delete();
        mod_ov = 1'b0; mod_un = 1'b0;
        chk_flags();
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step(0, '0, 0, 0);

        chk("pending_reads", 32'(exq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
